// File: rtl/paso_banda_svf.sv
// Second-order state-variable (Chamberlin) band-pass filter in signed Q8.12.
// Each EN strobe runs one full lp -> hp -> bp update in a single clock edge.
module paso_banda_svf #(
  parameter int W    = 21,
  parameter int FRAC = 12,
  parameter int F    = 1024,
  parameter int QD   = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] u,
  input  logic                EN,
  output logic signed [W-1:0] y1,
  output logic signed [W-1:0] y2,
  output logic signed [W-1:0] y3
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = W + 2;
  localparam int unsigned GW = PW - W + 1;

  localparam logic signed [W-1:0] C_F    = W'(F);
  localparam logic signed [W-1:0] C_QD   = W'(QD);
  localparam logic signed [W-1:0] C_MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] C_MINV = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] r_bp;
  logic signed [W-1:0] r_lp;
  logic signed [W-1:0] r_hp;

  logic signed [W-1:0]  w_mf_bp;
  logic signed [W-1:0]  w_mq_bp;
  logic signed [W-1:0]  w_mf_hp;
  logic signed [SW-1:0] w_lp_sum;
  logic signed [SW-1:0] w_hp_sum;
  logic signed [SW-1:0] w_bp_sum;
  logic signed [W-1:0]  w_lp_n;
  logic signed [W-1:0]  w_hp_n;
  logic signed [W-1:0]  w_bp_n;

  // Clamp a (W+2)-bit sum: in range only when the top three bits agree.
  function automatic logic signed [W-1:0] sat_sum(input logic signed [SW-1:0] x);
    logic signed [W-1:0] res;
    if (x[SW-1:W-1] == {3{x[SW-1]}}) begin
      res = x[W-1:0];
    end else if (x[SW-1]) begin
      res = C_MINV;
    end else begin
      res = C_MAXV;
    end
    return res;
  endfunction

  // Full-width product, floor shift by FRAC, then clamp back to W bits.
  function automatic logic signed [W-1:0] mul_q(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] s;
    logic signed [W-1:0]  res;
    p = PW'(a) * PW'(b);
    s = p >>> FRAC;
    if (s[PW-1:W-1] == {GW{s[PW-1]}}) begin
      res = s[W-1:0];
    end else if (s[PW-1]) begin
      res = C_MINV;
    end else begin
      res = C_MAXV;
    end
    return res;
  endfunction

  // Update chain; hp uses the new lp, bp uses the new hp.
  always_comb begin
    w_mf_bp  = mul_q(C_F, r_bp);
    w_mq_bp  = mul_q(C_QD, r_bp);
    w_lp_sum = SW'(r_lp) + SW'(w_mf_bp);
    w_lp_n   = sat_sum(w_lp_sum);
    w_hp_sum = SW'(u) - SW'(w_lp_n) - SW'(w_mq_bp);
    w_hp_n   = sat_sum(w_hp_sum);
    w_mf_hp  = mul_q(C_F, w_hp_n);
    w_bp_sum = SW'(r_bp) + SW'(w_mf_hp);
    w_bp_n   = sat_sum(w_bp_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bp <= '0;
      r_lp <= '0;
      r_hp <= '0;
    end else if (EN) begin
      r_bp <= w_bp_n;
      r_lp <= w_lp_n;
      r_hp <= w_hp_n;
    end
  end

  assign y1 = r_bp;
  assign y2 = r_lp;
  assign y3 = r_hp;

endmodule

// File: tb/tb_paso_banda_svf.sv
// Directed bench for paso_banda_svf: hand-computed vectors plus a
// bit-exact integer reference for the long DC and saturation sequences.
module tb_paso_banda_svf;

  localparam int W    = 21;
  localparam int FRAC = 12;
  localparam int F    = 1024;
  localparam int QD   = 4096;
  localparam longint VMAX = 1048575;
  localparam longint VMIN = -1048576;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                EN  = 1'b0;
  logic signed [W-1:0] u   = '0;
  logic signed [W-1:0] y1;
  logic signed [W-1:0] y2;
  logic signed [W-1:0] y3;

  int n_chk = 0;
  int n_err = 0;
  int n_clamp = 0;

  longint m_bp = 0;
  longint m_lp = 0;
  longint m_hp = 0;

  paso_banda_svf #(.W(W), .FRAC(FRAC), .F(F), .QD(QD)) dut (
    .clk (clk),
    .rst (rst),
    .u   (u),
    .EN  (EN),
    .y1  (y1),
    .y2  (y2),
    .y3  (y3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clampv(input longint x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  function automatic longint mulm(input longint a, input longint b);
    longint p;
    p = a * b;
    return clampv(p >>> FRAC);
  endfunction

  // Drive one clock of stimulus and advance the reference state alongside.
  task automatic step(input logic en_v, input logic rst_v, input longint u_v);
    longint lpn, hpn, bpn;
    @(negedge clk);
    EN  = en_v;
    rst = rst_v;
    u   = W'(u_v);
    @(posedge clk);
    #1;
    if (rst_v) begin
      m_bp = 0; m_lp = 0; m_hp = 0;
    end else if (en_v) begin
      lpn  = clampv(m_lp + mulm(F, m_bp));
      hpn  = clampv(u_v - lpn - mulm(QD, m_bp));
      bpn  = clampv(m_bp + mulm(F, hpn));
      m_lp = lpn; m_hp = hpn; m_bp = bpn;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_y1"}, longint'(y1), m_bp);
    chk({tag, "_y2"}, longint'(y2), m_lp);
    chk({tag, "_y3"}, longint'(y3), m_hp);
  endtask

  task automatic chk_abs(input string tag, input logic signed [W-1:0] y,
                         input longint y_ref, input longint y_lo, input longint y_hi);
    chk({tag, "_y1"}, longint'(y1), y_ref);
    chk({tag, "_y2"}, longint'(y2), y_lo);
    chk({tag, "_y3"}, longint'(y3), y_hi);
    if (y != y1) chk({tag, "_sel"}, longint'(y), longint'(y1));
  endtask

  initial begin
    // Reset held for 10 clocks with EN low.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 0);
    chk_abs("rst", y1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4096);
    chk_abs("rst_after", y1, 0, 0, 0);

    // Impulse response from zero state.
    step(1'b1, 1'b0, 4096);
    chk_abs("imp0", y1, 1024, 0, 4096);
    step(1'b1, 1'b0, 0);
    chk_abs("imp1", y1, 704, 256, -1280);

    // Hold with EN low while u toggles.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, (i % 2 == 0) ? VMAX : VMIN);
      chk_model("hold");
    end
    chk_abs("hold_end", y1, 704, 256, -1280);

    // DC step: low-pass tracks the input, band-pass and high-pass reject it.
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, 1'b0, 4096);
      chk_model("dc");
    end
    chk("dc_bp_small", longint'((y1 >= -3) && (y1 <= 3)), 1);
    chk("dc_hp_small", longint'((y3 >= -3) && (y3 <= 3)), 1);
    chk("dc_lp_near",  longint'((y2 >= 4090) && (y2 <= 4100)), 1);

    // Full-scale alternation drives the sums into clamping.
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, (i % 2 == 0) ? VMAX : VMIN);
      chk_model("sat");
      if (longint'(y1) == VMAX || longint'(y1) == VMIN ||
          longint'(y2) == VMAX || longint'(y2) == VMIN ||
          longint'(y3) == VMAX || longint'(y3) == VMIN) n_clamp++;
    end
    chk("sat_clamped", longint'(n_clamp > 0), 1);

    // Reset wins over a simultaneous sample strobe.
    step(1'b1, 1'b1, 4096);
    chk_abs("rst_prio", y1, 0, 0, 0);
    step(1'b1, 1'b0, 4096);
    chk_abs("post_rst_imp", y1, 1024, 0, 4096);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
